// File: rtl/glb_arb_pkg.sv
// Shared definitions for the GLB read-port arbiter and related NoC arbiters.
package glb_arb_pkg;

   // Arbiter FSM: IDLE picks an owner, GRANT streams that owner's beats.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Requester slot assignment on the shared GLB read port.
   localparam int REQ_IACT = 0;
   localparam int REQ_WGHT = 1;
   localparam int REQ_PSUM = 2;

   // Index width for n requesters; never narrower than one bit.
   function automatic int REQ_IDX_W(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/glb_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i,
// wrapping at NUM_REQ-1 -> 0 (NUM_REQ need not be a power of two).
module rr_pick
   import glb_arb_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = REQ_IDX_W(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic               found_o,
   output logic [IDX_W-1:0]   idx_o
);

   // Scan NUM_REQ slots starting from the pointer; the first hit wins.
   always_comb begin
      automatic int j = 0;
      found_o = 1'b0;
      idx_o   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(rr_ptr_i) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found_o && req_i[j]) begin
            found_o = 1'b1;
            idx_o   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/glb_read_arbiter.sv
// Shares the single GLB read port between router requesters with round-robin
// bounded bursts, and steers each returning word to the requester that issued it.
module glb_read_arbiter
   import glb_arb_pkg::*;
#(
   parameter int DATA_BITWIDTH     = 16,
   parameter int ADDR_BITWIDTH_GLB = 10,
   parameter int NUM_REQ           = 2,
   parameter int MAX_BURST         = 8,
   parameter int GLB_LATENCY       = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_REQ-1:0]                   req_i,
   input  logic [NUM_REQ*ADDR_BITWIDTH_GLB-1:0] addr_i,
   output logic [NUM_REQ-1:0]                   grant_o,
   output logic                                 glb_req_o,
   output logic [ADDR_BITWIDTH_GLB-1:0]         glb_addr_o,
   input  logic [DATA_BITWIDTH-1:0]             glb_data_i,
   output logic [DATA_BITWIDTH-1:0]             data_o,
   output logic [NUM_REQ-1:0]                   enable_o,
   output logic                                 busy_o
);

   localparam int IDX_W = REQ_IDX_W(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e                             state_q, state_d;
   logic [IDX_W-1:0]                       owner_q, owner_d;
   logic [IDX_W-1:0]                       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]                       beat_cnt_q, beat_cnt_d;
   logic [GLB_LATENCY-1:0]                 vld_pipe_q, vld_pipe_d;
   logic [GLB_LATENCY-1:0][IDX_W-1:0]      own_pipe_q, own_pipe_d;

   logic                                   pick_found;
   logic [IDX_W-1:0]                       pick_idx;
   logic [NUM_REQ-1:0]                     own_vec;
   logic                                   own_req;
   logic [ADDR_BITWIDTH_GLB-1:0]           own_addr;
   logic [IDX_W-1:0]                       ptr_inc;
   logic [CNT_W-1:0]                       cnt_nxt;
   logic                                   others;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i    (req_i),
      .rr_ptr_i (rr_ptr_q),
      .found_o  (pick_found),
      .idx_o    (pick_idx)
   );

   // Select the current owner's request, address and one-hot grant.
   always_comb begin
      own_vec  = '0;
      own_req  = 1'b0;
      own_addr = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (owner_q == IDX_W'(k)) begin
            own_vec[k] = 1'b1;
            own_req    = req_i[k];
            own_addr   = addr_i[k*ADDR_BITWIDTH_GLB +: ADDR_BITWIDTH_GLB];
         end
      end
   end

   // FSM next state, burst counting, release and GLB strobe.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      grant_o    = '0;
      glb_req_o  = 1'b0;
      glb_addr_o = '0;
      ptr_inc    = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
      cnt_nxt    = beat_cnt_q + 1'b1;
      others     = |(req_i & ~own_vec);
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               owner_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            grant_o    = own_vec;
            glb_req_o  = own_req;
            glb_addr_o = own_addr;
            if (!own_req) begin
               // owner stopped asking: hand the port on
               state_d  = IDLE;
               rr_ptr_d = ptr_inc;
            end else if (cnt_nxt == CNT_W'(MAX_BURST)) begin
               // burst limit only forces release if someone else is waiting
               beat_cnt_d = '0;
               if (others) begin
                  state_d  = IDLE;
                  rr_ptr_d = ptr_inc;
               end
            end else begin
               beat_cnt_d = cnt_nxt;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Return-path tag pipeline: one {valid, owner} entry per GLB latency cycle.
   always_comb begin
      vld_pipe_d    = vld_pipe_q;
      own_pipe_d    = own_pipe_q;
      vld_pipe_d[0] = glb_req_o;
      own_pipe_d[0] = owner_q;
      for (int i = 1; i < GLB_LATENCY; i++) begin
         vld_pipe_d[i] = vld_pipe_q[i-1];
         own_pipe_d[i] = own_pipe_q[i-1];
      end
   end

   // Route the returning word to the requester that issued it.
   always_comb begin
      enable_o = '0;
      for (int k = 0; k < NUM_REQ; k++)
         enable_o[k] = vld_pipe_q[GLB_LATENCY-1] & (own_pipe_q[GLB_LATENCY-1] == IDX_W'(k));
      data_o = (|enable_o) ? glb_data_i : '0;
      busy_o = (state_q == GRANT) | (|vld_pipe_q);
   end

   // State registers; reset drops any reads still in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         vld_pipe_q <= '0;
         own_pipe_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         vld_pipe_q <= vld_pipe_d;
         own_pipe_q <= own_pipe_d;
      end
   end

endmodule
